// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone RAM slave: FSM state encoding,
// wait-counter width and the even-parity helper.
package wb_pkg;

  localparam int WS_W  = 4;
  localparam int PAR_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_t;

  // Even parity over up to PAR_W bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [PAR_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/wb_ram_core.sv
// Synchronous single-port storage array with write enable and a registered
// read port that samples the addressed word on every clock edge.
module wb_ram_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read-before-write on a shared address; the slave never consumes the read
  // word produced on a write edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave with programmable wait states before ack.
// Define WB_RAM_PARITY_EN to add one even-parity bit per word and a sticky parity_err output.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_dat_w,
  output logic [DATA_WIDTH-1:0] wb_dat_r,
  output logic                  wb_ack
`ifdef WB_RAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef WB_RAM_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int MEM_W = DATA_WIDTH + PAR_BITS;

  wb_state_t             r_state;
  wb_state_t             w_next;
  logic [WS_W-1:0]       r_cnt;
  logic                  r_we;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_hold;

  logic                  w_capture;
  logic                  w_rd_ack;
  logic [IDX_W-1:0]      w_idx;
  logic [MEM_W-1:0]      w_mem_wdata;
  logic [MEM_W-1:0]      w_mem_rdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_adr;

  // Address bits above the word index and the byte lane bits alias away.
  assign w_unused_adr = ^wb_adr;

  assign w_capture = (r_state == IDLE) && wb_cyc && wb_stb;
  assign w_rd_ack  = (r_state == ACK) && !r_we;
  assign w_idx     = (r_state == IDLE) ? wb_adr[IDX_W+1:2] : r_idx;
  assign w_rdata   = w_mem_rdata[DATA_WIDTH-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (wb_cyc && wb_stb) w_next = (WAIT_STATES > 0) ? WAIT : ACK;
      WAIT:    if (r_cnt == '0) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == WAIT) begin
        r_cnt <= WS_W'(WAIT_STATES - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_we  <= wb_we;
        r_idx <= wb_adr[IDX_W+1:2];
      end
      if (w_rd_ack) begin
        r_hold <= w_rdata;
      end
    end
  end

  assign wb_ack = (r_state == ACK);
  // The read word is forwarded straight from the array in the ack cycle, then held.
  assign wb_dat_r = w_rd_ack ? w_rdata : r_hold;

`ifdef WB_RAM_PARITY_EN
  logic r_parity_err;

  assign w_mem_wdata = {even_parity(PAR_W'(wb_dat_w)), wb_dat_w};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_rd_ack && (even_parity(PAR_W'(w_rdata)) != w_mem_rdata[DATA_WIDTH])) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign w_mem_wdata = wb_dat_w;
`endif

  wb_ram_core #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_capture && wb_we),
    .i_addr  (w_idx),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances with WAIT_STATES 1, 0 and 3.
// Parity checks are compiled in when WB_RAM_PARITY_EN is defined.
module tb_wb_ram_slave;

  logic        clk;
  logic        rst;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  we;
  logic [2:0]  ack;
  logic [31:0] adr   [3];
  logic [31:0] dat_w [3];
  logic [31:0] dat_r [3];
`ifdef WB_RAM_PARITY_EN
  logic [2:0]  pe;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  wb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]),
    .wb_adr(adr[0]), .wb_dat_w(dat_w[0]), .wb_dat_r(dat_r[0]), .wb_ack(ack[0])
`ifdef WB_RAM_PARITY_EN
    , .parity_err(pe[0])
`endif
  );

  wb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut1 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]),
    .wb_adr(adr[1]), .wb_dat_w(dat_w[1]), .wb_dat_r(dat_r[1]), .wb_ack(ack[1])
`ifdef WB_RAM_PARITY_EN
    , .parity_err(pe[1])
`endif
  );

  wb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut2 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_we(we[2]),
    .wb_adr(adr[2]), .wb_dat_w(dat_w[2]), .wb_dat_r(dat_r[2]), .wb_ack(ack[2])
`ifdef WB_RAM_PARITY_EN
    , .parity_err(pe[2])
`endif
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One-cycle cyc/stb pulse; returns at the first falling edge after the capture edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] dw);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = dw;
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  // Latency counted in cycles after capture: the first sample is cycle N+1.
  task automatic wait_ack(input int d, output int lat);
    lat = 1;
    while (ack[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic xfer_write(input int d, input logic [31:0] a, input logic [31:0] dw,
                            input int exp_lat, input string tag);
    int lat;
    issue(d, 1'b1, a, dw);
    wait_ack(d, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_ack_1cyc"}, 32'(ack[d]), 32'd0);
  endtask

  task automatic xfer_read(input int d, input logic [31:0] a, input logic [31:0] exp_data,
                           input int exp_lat, input string tag);
    int lat;
    logic [31:0] e;
    exp_q.push_back(exp_data);
    issue(d, 1'b0, a, 32'h0);
    wait_ack(d, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    check({tag, "_data"}, dat_r[d], e);
    @(negedge clk);
    check({tag, "_ack_1cyc"}, 32'(ack[d]), 32'd0);
    check({tag, "_hold"}, dat_r[d], e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_acks;
    int ack_at;
    rst = 1'b1;
    cyc = '0; stb = '0; we = '0;
    for (int d = 0; d < 3; d++) begin
      adr[d] = '0; dat_w[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("idle_ack_d%0d", d), 32'(ack[d]), 32'd0);
        check($sformatf("idle_dat_d%0d", d), dat_r[d], 32'd0);
`ifdef WB_RAM_PARITY_EN
        check($sformatf("idle_pe_d%0d", d), 32'(pe[d]), 32'd0);
`endif
      end
    end

    // WAIT_STATES=1: write then read, writes leave dat_r alone, read-after-write
    xfer_write(0, 32'h10, 32'hDEADBEEF, 2, "ws1_wr");
    xfer_read (0, 32'h10, 32'hDEADBEEF, 2, "ws1_rd");
    xfer_write(0, 32'h10, 32'h0BADF00D, 2, "ws1_wr2");
    check("ws1_dat_after_wr", dat_r[0], 32'hDEADBEEF);
    xfer_read (0, 32'h10, 32'h0BADF00D, 2, "ws1_raw");

    // WAIT_STATES=0: aliasing above the index and byte-lane bits ignored
    xfer_write(1, 32'h1000, 32'h12345678, 1, "ws0_wr");
    xfer_read (1, 32'h0000, 32'h12345678, 1, "ws0_alias");
    xfer_write(1, 32'h0008, 32'hCAFE0001, 1, "ws0_wr8");
    xfer_read (1, 32'h000B, 32'hCAFE0001, 1, "ws0_lane");

    // WAIT_STATES=3: a strobe during WAIT is dropped
    xfer_write(2, 32'h20, 32'hAAAA5555, 4, "ws3_wr");
    issue(2, 1'b1, 32'h30, 32'h11112222);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; dat_w[2] = 32'hFFFFFFFF;
    n_acks = 0;
    ack_at = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        cyc[2] = 1'b0; stb[2] = 1'b0;
      end
      if (ack[2] === 1'b1) begin
        n_acks++;
        ack_at = i;
      end
      @(negedge clk);
    end
    check("ws3_stray_nacks", 32'(n_acks), 32'd1);
    check("ws3_stray_lat", 32'(ack_at), 32'd4);
    xfer_read(2, 32'h20, 32'hAAAA5555, 4, "ws3_rd20");
    xfer_read(2, 32'h30, 32'h11112222, 4, "ws3_rd30");

    // Reset one cycle after a read capture aborts it
    issue(0, 1'b0, 32'h10, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_ack", 32'(ack[0]), 32'd0);
    check("rst_abort_dat", dat_r[0], 32'd0);
    rst = 1'b0;
    n_acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) n_acks++;
    end
    check("rst_abort_noack", 32'(n_acks), 32'd0);
    xfer_read(0, 32'h10, 32'h0BADF00D, 2, "rst_after_rd");
    xfer_read(1, 32'h0, 32'h12345678, 1, "rst_keep_mem");

`ifdef WB_RAM_PARITY_EN
    // Corrupt the stored parity bit of word 5
    xfer_write(0, 32'h14, 32'h0F0F0F0F, 2, "par_wr");
    xfer_read (0, 32'h14, 32'h0F0F0F0F, 2, "par_rd_ok");
    check("par_clean", 32'(pe[0]), 32'd0);
    dut0.u_core.r_mem[5][32] = ~dut0.u_core.r_mem[5][32];
    xfer_read (0, 32'h14, 32'h0F0F0F0F, 2, "par_rd_bad");
    check("par_err_set", 32'(pe[0]), 32'd1);
    repeat (3) @(negedge clk);
    check("par_err_sticky", 32'(pe[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("par_err_cleared", 32'(pe[0]), 32'd0);
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
